// File: rtl/watchdog_timer_pkg.sv
// Shared definitions for the watchdog timer: register map, CTRL/STATUS bit
// positions, FSM state encoding and the default kick key.
package watchdog_timer_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'b00;
  localparam logic [1:0] ADDR_COUNT   = 2'b01;
  localparam logic [1:0] ADDR_TIMEOUT = 2'b10;
  localparam logic [1:0] ADDR_STATUS  = 2'b11;

  localparam int CTRL_CANCEL = 0;
  localparam int CTRL_FORCE  = 1;
  localparam int CTRL_WIN_EN = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_PAUSED = 15;

  localparam int STAT_WARN = 0;
  localparam int STAT_WIN  = 1;
  localparam int STAT_KEY  = 2;
  localparam int STAT_TMO  = 3;

  localparam logic [15:0] DEFAULT_KICK_KEY = 16'hA5C3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WARN = 2'd1,
    ST_FIRE = 2'd2
  } wdt_state_e;

endpackage

// File: rtl/watchdog_timer_prescaler.sv
// Free-running PRE_W-bit prescaler for the watchdog. Synchronous clear has
// priority over enable; o_tc flags the all-ones terminal count.
module wdt_prescaler #(
  parameter int unsigned PRE_W = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [PRE_W-1:0] pre_q, pre_d;

  // Next prescaler value: clear wins, otherwise count while enabled
  always_comb begin
    pre_d = pre_q;
    if (i_clr) begin
      pre_d = '0;
    end else if (i_en) begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Prescaler register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign o_tc = &pre_q;

endmodule

// File: rtl/watchdog_timer.sv
// Memory-mapped watchdog with programmable timeout, prescaler, keyed kick,
// early-warning interrupt and stretched reset pulse.
// Define WATCHDOG_WINDOW_EN to build the early-kick window check; without it
// CTRL bit2 reads 0, STATUS bit1 reads 0 and every correct-key kick is taken.
module watchdog_timer
  import watchdog_timer_pkg::*;
#(
  parameter int unsigned PRE_W     = 4,
  parameter logic [15:0] WARN_LEAD = 16'd64,
  parameter int unsigned RST_PULSE = 4,
  parameter logic [15:0] KICK_KEY  = DEFAULT_KICK_KEY
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_memAddr,
  input  logic [15:0] i_memDataIn,
  input  logic        i_memWrEn,
  output logic [15:0] o_memDataOut,
  input  logic        i_smIsBooted,
  input  logic        i_smStartPause,
  output logic        o_doReset,
  output logic        o_warnIrq
);
  // Pulse counter is loaded with the last index so o_doReset spans RST_PULSE cycles
  localparam logic [3:0] PULSE_LAST = 4'(RST_PULSE - 1);

  wdt_state_e  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] timeout_q, timeout_d;
  logic        cancel_q, cancel_d;
  logic        irq_en_q, irq_en_d;
  logic        warn_pend_q, warn_pend_d;
  logic        st_win_q, st_win_d;
  logic        st_key_q, st_key_d;
  logic        st_tmo_q, st_tmo_d;
  logic        do_reset_q, do_reset_d;
  logic        warn_irq_q, warn_irq_d;
  logic [3:0]  pulse_q, pulse_d;

  logic        in_fire, paused, fire, fire_done;
  logic        ctrl_wr, kick_wr, kick_good, status_wr, timeout_wr;
  logic        pre_en, pre_clr, pre_tc, tick;
  logic [16:0] cnt_nxt, warn_thr;
  logic        win_en, win_violate;

  assign in_fire    = (state_q == ST_FIRE);
  assign paused     = ~i_smIsBooted | i_smStartPause;
  // Kicks and CTRL writes are dropped while the reset pulse is out
  assign ctrl_wr    = i_memWrEn & (i_memAddr == ADDR_CTRL) & ~in_fire;
  assign kick_wr    = i_memWrEn & (i_memAddr == ADDR_COUNT) & ~in_fire;
  assign kick_good  = kick_wr & (i_memDataIn == KICK_KEY);
  assign status_wr  = i_memWrEn & (i_memAddr == ADDR_STATUS);
  assign timeout_wr = i_memWrEn & (i_memAddr == ADDR_TIMEOUT);
  assign fire_done  = in_fire & (pulse_q == 4'd0);

  assign pre_en  = ~paused & ~cancel_q & ~in_fire;
  assign pre_clr = ctrl_wr | kick_good | fire_done;
  assign tick    = pre_tc & pre_en;

  // 17-bit compares so COUNT+1 cannot wrap at 16'hFFFF
  assign cnt_nxt  = {1'b0, count_q} + 17'd1;
  assign warn_thr = (timeout_q > WARN_LEAD) ? {1'b0, timeout_q - WARN_LEAD} : 17'd0;

`ifdef WATCHDOG_WINDOW_EN
  logic win_en_q, win_en_d;

  // Window-enable bit follows CTRL writes taken outside FIRE
  always_comb begin
    win_en_d = win_en_q;
    if (ctrl_wr) begin
      win_en_d = i_memDataIn[CTRL_WIN_EN];
    end
  end

  // Window-enable register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_en_q <= 1'b0;
    end else begin
      win_en_q <= win_en_d;
    end
  end

  assign win_en      = win_en_q;
  assign win_violate = win_en_q & (count_q < (timeout_q >> 1));
`else
  assign win_en      = 1'b0;
  assign win_violate = 1'b0;
`endif

  wdt_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (pre_clr),
    .i_en  (pre_en),
    .o_tc  (pre_tc)
  );

  // Next-state, register-update and fire decisions
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timeout_d   = timeout_q;
    cancel_d    = cancel_q;
    irq_en_d    = irq_en_q;
    warn_pend_d = warn_pend_q;
    st_win_d    = st_win_q;
    st_key_d    = st_key_q;
    st_tmo_d    = st_tmo_q;
    do_reset_d  = do_reset_q;
    pulse_d     = pulse_q;
    fire        = 1'b0;

    if (timeout_wr) begin
      timeout_d = i_memDataIn;
    end
    if (ctrl_wr) begin
      cancel_d = i_memDataIn[CTRL_CANCEL];
      irq_en_d = i_memDataIn[CTRL_IRQ_EN];
    end
    // Clear first so a warning raised this same cycle still sticks
    if (status_wr && i_memDataIn[STAT_WARN]) begin
      warn_pend_d = 1'b0;
    end

    case (state_q)
      ST_RUN, ST_WARN: begin
        if (ctrl_wr) begin
          count_d = '0;
          fire    = i_memDataIn[CTRL_FORCE];
        end else if (kick_wr) begin
          if (!kick_good) begin
            fire     = 1'b1;
            st_key_d = 1'b1;
          end else if (win_violate) begin
            fire     = 1'b1;
            st_win_d = 1'b1;
          end else begin
            count_d = '0;
            state_d = ST_RUN;
          end
        end else if (tick) begin
          count_d = (count_q == 16'hFFFF) ? count_q : cnt_nxt[15:0];
          if (state_q == ST_RUN && cnt_nxt >= warn_thr) begin
            warn_pend_d = 1'b1;
            state_d     = ST_WARN;
          end
          if (cnt_nxt >= {1'b0, timeout_q}) begin
            fire     = 1'b1;
            st_tmo_d = 1'b1;
          end
        end
        if (fire) begin
          state_d    = ST_FIRE;
          do_reset_d = 1'b1;
          pulse_d    = PULSE_LAST;
        end
      end
      ST_FIRE: begin
        if (fire_done) begin
          state_d    = ST_RUN;
          do_reset_d = 1'b0;
          count_d    = '0;
        end else begin
          pulse_d = pulse_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    warn_irq_d = warn_pend_d & irq_en_d;
  end

  // State and register file
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      timeout_q   <= 16'hFFFF;
      cancel_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      warn_pend_q <= 1'b0;
      st_win_q    <= 1'b0;
      st_key_q    <= 1'b0;
      st_tmo_q    <= 1'b0;
      do_reset_q  <= 1'b0;
      warn_irq_q  <= 1'b0;
      pulse_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timeout_q   <= timeout_d;
      cancel_q    <= cancel_d;
      irq_en_q    <= irq_en_d;
      warn_pend_q <= warn_pend_d;
      st_win_q    <= st_win_d;
      st_key_q    <= st_key_d;
      st_tmo_q    <= st_tmo_d;
      do_reset_q  <= do_reset_d;
      warn_irq_q  <= warn_irq_d;
      pulse_q     <= pulse_d;
    end
  end

  // Combinational read mux
  always_comb begin
    o_memDataOut = '0;
    case (i_memAddr)
      ADDR_CTRL: begin
        o_memDataOut[CTRL_CANCEL] = cancel_q;
        o_memDataOut[CTRL_WIN_EN] = win_en;
        o_memDataOut[CTRL_IRQ_EN] = irq_en_q;
        o_memDataOut[CTRL_PAUSED] = paused;
      end
      ADDR_COUNT:   o_memDataOut = count_q;
      ADDR_TIMEOUT: o_memDataOut = timeout_q;
      default: begin
        o_memDataOut[STAT_WARN] = warn_pend_q;
        o_memDataOut[STAT_WIN]  = st_win_q;
        o_memDataOut[STAT_KEY]  = st_key_q;
        o_memDataOut[STAT_TMO]  = st_tmo_q;
      end
    endcase
  end

  assign o_doReset = do_reset_q;
  assign o_warnIrq = warn_irq_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// Self-checking bench for watchdog_timer: directed scenarios plus random
// register traffic, all compared every cycle against a behavioural model.
module tb_watchdog_timer;
  localparam int          PRE_W     = 2;
  localparam int          PRE_DIV   = 1 << PRE_W;
  localparam int          RST_PULSE = 4;
  localparam logic [15:0] LEAD      = 16'd64;
  localparam logic [15:0] KEY       = 16'hA5C3;
`ifdef WATCHDOG_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic        i_clk, i_rst;
  logic [1:0]  i_memAddr;
  logic [15:0] i_memDataIn;
  logic        i_memWrEn;
  logic [15:0] o_memDataOut;
  logic        i_smIsBooted, i_smStartPause;
  logic        o_doReset, o_warnIrq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_count, m_phase, m_fire_left;
  logic [15:0] m_timeout;
  bit          m_cancel, m_win_en, m_irq_en, m_warn, m_in_warn;
  bit          m_st_win, m_st_key, m_st_tmo;

  watchdog_timer #(
    .PRE_W     (PRE_W),
    .WARN_LEAD (LEAD),
    .RST_PULSE (RST_PULSE),
    .KICK_KEY  (KEY)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_memAddr      (i_memAddr),
    .i_memDataIn    (i_memDataIn),
    .i_memWrEn      (i_memWrEn),
    .o_memDataOut   (o_memDataOut),
    .i_smIsBooted   (i_smIsBooted),
    .i_smStartPause (i_smStartPause),
    .o_doReset      (o_doReset),
    .o_warnIrq      (o_warnIrq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL guard: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_phase = 0; m_fire_left = 0; m_timeout = 16'hFFFF;
    m_cancel = 0; m_win_en = 0; m_irq_en = 0; m_warn = 0; m_in_warn = 0;
    m_st_win = 0; m_st_key = 0; m_st_tmo = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] a);
    logic [15:0] v;
    v = '0;
    case (a)
      2'b00: begin
        v[0] = m_cancel; v[2] = m_win_en; v[3] = m_irq_en;
        v[15] = !i_smIsBooted || i_smStartPause;
      end
      2'b01:   v = m_count[15:0];
      2'b10:   v = m_timeout;
      default: v = {12'b0, m_st_tmo, m_st_key, m_st_win, m_warn};
    endcase
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_edge(input logic [1:0] a, input logic [15:0] d, input logic we);
    bit          en, tick, fire;
    int          nxt, thr;
    logic [15:0] old_to;
    if (i_rst) begin
      model_reset();
      return;
    end
    old_to = m_timeout;
    fire   = 0;
    if (we && a == 2'b11 && d[0]) m_warn = 0;
    if (m_fire_left > 0) begin
      m_fire_left--;
      if (m_fire_left == 0) begin m_count = 0; m_phase = 0; end
    end else begin
      en   = i_smIsBooted && !i_smStartPause && !m_cancel;
      tick = en && (m_phase == PRE_DIV - 1);
      if (en) m_phase = (m_phase + 1) % PRE_DIV;
      if (we && a == 2'b00) begin
        m_cancel = d[0]; m_irq_en = d[3];
        if (WIN) m_win_en = d[2];
        m_count = 0; m_phase = 0; fire = d[1];
      end else if (we && a == 2'b01) begin
        if (d != KEY) begin
          fire = 1; m_st_key = 1;
        end else if (m_win_en && m_count < int'(old_to / 2)) begin
          fire = 1; m_st_win = 1;
        end else begin
          m_count = 0; m_phase = 0; m_in_warn = 0;
        end
      end else if (tick) begin
        nxt = m_count + 1;
        thr = (old_to > LEAD) ? int'(old_to - LEAD) : 0;
        if (!m_in_warn && nxt >= thr) begin m_warn = 1; m_in_warn = 1; end
        if (nxt >= int'(old_to)) begin fire = 1; m_st_tmo = 1; end
        m_count = (nxt > 65535) ? 65535 : nxt;
      end
      if (fire) begin m_fire_left = RST_PULSE; m_in_warn = 0; end
    end
    if (we && a == 2'b10) m_timeout = d;
  endtask

  // One bus cycle: drive, check read mux, clock, check registered outputs
  task automatic cycle(input logic [1:0] a, input logic [15:0] d, input logic we);
    i_memAddr = a; i_memDataIn = d; i_memWrEn = we;
    #1;
    chk("rd", o_memDataOut, model_read(a));
    model_edge(a, d, we);
    @(posedge i_clk);
    #1;
    chk("doReset", {15'b0, o_doReset}, {15'b0, (m_fire_left > 0)});
    chk("warnIrq", {15'b0, o_warnIrq}, {15'b0, (m_warn && m_irq_en)});
    i_memWrEn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(2'b01, 16'h0000, 1'b0);
  endtask

  task automatic pulse_rst();
    i_rst = 1'b1;
    cycle(2'b10, 16'h0000, 1'b0);
    i_rst = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    i_memAddr = a;
    #1;
    chk(tag, o_memDataOut, exp);
  endtask

  initial begin
    int n;
    logic [1:0]  ra;
    logic [15:0] rd;
    i_rst = 1'b1; i_memAddr = '0; i_memDataIn = '0; i_memWrEn = 1'b0;
    i_smIsBooted = 1'b1; i_smStartPause = 1'b0;
    @(posedge i_clk);
    #1;
    model_reset();
    cycle(2'b10, 16'h0000, 1'b0);
    i_rst = 1'b0;
    rd_chk("rst_timeout", 2'b10, 16'hFFFF);
    rd_chk("rst_status", 2'b11, 16'h0000);

    // Timeout with no kicks, warn IRQ masked
    pulse_rst();
    cycle(2'b10, 16'd8, 1'b1);
    cycle(2'b00, 16'h0000, 1'b1);
    n = 0;
    while (o_doReset !== 1'b1 && n < 100) begin idle(1); n++; end
    chk("fire_lat", n[15:0], 16'(8 * PRE_DIV));
    n = 0;
    while (o_doReset === 1'b1 && n < 20) begin idle(1); n++; end
    chk("pulse_len", n[15:0], 16'(RST_PULSE));
    i_memAddr = 2'b11; #1;
    chk("tmo_status", {13'b0, o_memDataOut[3:1]}, 16'b100);

    // Early warning, kick, W1C
    pulse_rst();
    cycle(2'b10, 16'd100, 1'b1);
    cycle(2'b00, 16'h0008, 1'b1);
    n = 0;
    while (o_warnIrq !== 1'b1 && n < 300) begin idle(1); n++; end
    chk("warn_lat", n[15:0], 16'(36 * PRE_DIV));
    rd_chk("warn_cnt", 2'b01, 16'd36);
    cycle(2'b01, KEY, 1'b1);
    rd_chk("kick_clr", 2'b01, 16'd0);
    cycle(2'b11, 16'h0001, 1'b1);
    chk("w1c_irq", {15'b0, o_warnIrq}, 16'd0);

    // Bad key
    cycle(2'b01, 16'h1234, 1'b1);
    chk("badkey_rst", {15'b0, o_doReset}, 16'd1);
    i_memAddr = 2'b11; #1;
    chk("badkey_stat", {15'b0, o_memDataOut[2]}, 16'd1);
    idle(6);

    // Window: early kick then in-window kick
    pulse_rst();
    cycle(2'b10, 16'd20, 1'b1);
    cycle(2'b00, 16'h0004, 1'b1);
    idle(5 * PRE_DIV);
    rd_chk("win_cnt5", 2'b01, 16'd5);
    cycle(2'b01, KEY, 1'b1);
    chk("win_early", {15'b0, o_doReset}, {15'b0, WIN});
    idle(6);
    i_memAddr = 2'b11; #1;
    chk("win_flag", {15'b0, o_memDataOut[1]}, {15'b0, WIN});
    cycle(2'b00, 16'h0004, 1'b1);
    idle(12 * PRE_DIV);
    rd_chk("win_cnt12", 2'b01, 16'd12);
    cycle(2'b01, KEY, 1'b1);
    chk("win_ok", {15'b0, o_doReset}, 16'd0);

    // Debug pause freezes count and prescaler
    pulse_rst();
    cycle(2'b10, 16'd1000, 1'b1);
    cycle(2'b00, 16'h0000, 1'b1);
    idle(10);
    rd_chk("pre_pause", 2'b01, 16'd2);
    i_smStartPause = 1'b1;
    idle(50);
    i_memAddr = 2'b00; #1;
    chk("paused_flag", {15'b0, o_memDataOut[15]}, 16'd1);
    rd_chk("pause_hold", 2'b01, 16'd2);
    i_smStartPause = 1'b0;
    idle(2);
    rd_chk("resume", 2'b01, 16'd3);

    // Reset in the middle of FIRE
    cycle(2'b00, 16'h0002, 1'b1);
    chk("force_rst", {15'b0, o_doReset}, 16'd1);
    idle(1);
    i_rst = 1'b1;
    cycle(2'b01, 16'h0000, 1'b0);
    chk("rst_in_fire", {15'b0, o_doReset}, 16'd0);
    i_rst = 1'b0;
    rd_chk("rst_fire_to", 2'b10, 16'hFFFF);

    // Random register traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        i_smIsBooted   = ($urandom_range(0, 9) != 0);
        i_smStartPause = ($urandom_range(0, 6) == 0);
      end
      ra = 2'($urandom_range(0, 3));
      n  = int'($urandom_range(0, 99));
      if (n < 1) begin
        pulse_rst();
      end else if (n < 9) begin
        case (ra)
          2'b00:   rd = {12'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0)};
          2'b01:   rd = ($urandom_range(0, 4) != 0) ? KEY : 16'($urandom);
          2'b10:   rd = 16'($urandom_range(1, 80));
          default: rd = 16'($urandom_range(0, 15));
        endcase
        cycle(ra, rd, 1'b1);
      end else begin
        cycle(ra, 16'($urandom), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
